multicycle_control: RTL

Main control FSM for the multi-cycle RISC-V CPU. It sequences the shared datapath (PC, IR, ALU, unified memory, register file) through fetch/decode/execute/memory/writeback steps. It is also the only source of the register file's RegWrite strobe. It talks to unified memory through a req/ready handshake, counts retired instructions, and halts on an illegal opcode.

---
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the shared datapath /
// unified memory. The controller drives the strobes and selects; the IR opcode
// field and the memory completion flag come back in.
//
// Handshake: mem_req is raised by the controller and held, together with every
// other control output, until a cycle in which mem_ready=1; that cycle completes
// the access. mem_ready seen while mem_req=0 carries no meaning and is ignored.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    // Controller side.
    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
               illegal, instret
    );

    // Datapath / memory side.
    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
               illegal, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V core. Sequences fetch, decode,
// execute, memory and writeback over the shared datapath, owns the register
// file write strobe, counts retired instructions and stops on illegal opcodes.
// Control outputs are decoded from the state register alone (FETCH additionally
// qualifies ir_write/pc_write with mem_ready) and are forced low while rst_n is
// low so that an aborted access drops immediately.
module multicycle_control #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_if.master       bus,
    output logic [3:0]                 state_dbg
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_LDWB   = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q;

    // State sequencing, retired-instruction counter and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_R:              state <= S_EXEC_R;
                        OP_I:              state <= S_EXEC_I;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
                        default: begin
                            if (HALT_ON_ILLEGAL) begin
                                state     <= S_HALT;
                                illegal_q <= 1'b1;
                            end else begin
                                // Illegal opcode retires as a NOP.
                                state     <= S_FETCH;
                                instret_q <= instret_q + CNT_W'(1);
                            end
                        end
                    endcase
                end
                // IR is stable, so the opcode is simply looked at again here.
                S_MEMADR: state <= (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (bus.mem_ready) state <= S_LDWB;
                S_MEMWR: begin
                    if (bus.mem_ready) begin
                        state     <= S_FETCH;
                        instret_q <= instret_q + CNT_W'(1);
                    end
                end
                S_EXEC_R, S_EXEC_I: state <= S_ALUWB;
                S_LDWB, S_ALUWB, S_BRANCH, S_JAL: begin
                    state     <= S_FETCH;
                    instret_q <= instret_q + CNT_W'(1);
                end
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Moore control decode; everything low during reset.
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 2'd0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = 2'b00;
        bus.mem_to_reg    = 2'd0;
        bus.reg_write     = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = 2'd1;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE: bus.alu_src_b = 2'd2;
                S_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.i_or_d  = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                S_LDWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 2'd1;
                end
                S_EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    bus.alu_op    = 2'b10;
                end
                S_ALUWB: bus.reg_write = 1'b1;
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'd1;
                end
                S_JAL: begin
                    // PC already holds old PC + 4, which is the link value.
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 2'd2;
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.instret = instret_q;
    assign bus.illegal = illegal_q;
    assign state_dbg   = state;
endmodule
